// File: rtl/cond_flag_ctrl.sv
// cond_flag_ctrl
//   Conditional-execution sequencer for the ID stage. Holds the architectural
//   NZCV status register, tracks how many flag-setting instructions are still
//   in flight, stalls conditional instructions until their flags are known
//   (bypassing the EX result when it is the only outstanding writer), and
//   resolves each ID instruction to pass (execute) or fail (issue as NOP).
//
//   Ports
//     clk, rst_n      clock (rising edge), async active-low reset
//     id_valid        valid instruction in ID
//     id_cond         condition field (0 EQ .. 13 LE, 14 AL, 15 never)
//     id_s            ID instruction writes flags
//     freeze          pipeline freeze, ID does not advance
//     flush           taken branch, younger in-flight work is killed
//     ex_flags_valid  a counted flag writer completes in EX this cycle
//     ex_nzcv         flags from EX {N,Z,C,V}
//     stall           hold ID/IF
//     cond_pass       ID instruction issues and executes
//     cond_fail       ID instruction issues as NOP
//     sr_nzcv         status register {N,Z,C,V}
//     pending         outstanding flag writers
//     err             sticky: completion seen with nothing pending
//
//   state | meaning
//   RUN   | ID not stalled last cycle
//   HOLD  | ID stalled last cycle; debug stall counter runs
module cond_flag_ctrl #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [3:0]       id_cond,
   input  logic             id_s,
   input  logic             freeze,
   input  logic             flush,
   input  logic             ex_flags_valid,
   input  logic [3:0]       ex_nzcv,
   output logic             stall,
   output logic             cond_pass,
   output logic             cond_fail,
   output logic [3:0]       sr_nzcv,
   output logic [CNT_W-1:0] pending,
   output logic             err
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               DBG_W   = 8;

   state_t           state_q, state_d;
   logic [3:0]       sr_nzcv_q, sr_nzcv_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             err_q, err_d;
   logic [DBG_W-1:0] stall_left_q, stall_left_d;

   logic       pend_zero;
   logic       flags_ok;
   logic [3:0] flags_sel;
   logic       cond_true;
   logic       needs_flags;
   logic       stall_raw;
   logic       issue;
   logic       inc, dec;
   logic       n_f, z_f, c_f, v_f;

   assign pend_zero = (pending_q == '0);

   // Flags are known either from the SR (nothing in flight) or from the
   // single outstanding writer completing right now.
   assign flags_ok  = pend_zero || ((pending_q == CNT_ONE) && ex_flags_valid);
   assign flags_sel = pend_zero ? sr_nzcv_q : ex_nzcv;
   assign {n_f, z_f, c_f, v_f} = flags_sel;

   always_comb begin
      cond_true = 1'b0;
      case (id_cond)
         4'd0:    cond_true = z_f;
         4'd1:    cond_true = !z_f;
         4'd2:    cond_true = c_f;
         4'd3:    cond_true = !c_f;
         4'd4:    cond_true = n_f;
         4'd5:    cond_true = !n_f;
         4'd6:    cond_true = v_f;
         4'd7:    cond_true = !v_f;
         4'd8:    cond_true = c_f && !z_f;
         4'd9:    cond_true = !c_f || z_f;
         4'd10:   cond_true = (n_f == v_f);
         4'd11:   cond_true = (n_f != v_f);
         4'd12:   cond_true = !z_f && (n_f == v_f);
         4'd13:   cond_true = z_f || (n_f != v_f);
         4'd14:   cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   assign needs_flags = (id_cond < 4'd14);

   // Second term: a new flag writer would overflow the counter unless a
   // completion frees a slot in the same cycle.
   assign stall_raw = id_valid &&
                      ((needs_flags && !flags_ok) ||
                       (id_s && (pending_q == CNT_MAX) && !ex_flags_valid));
   assign stall     = stall_raw && !flush;
   assign issue     = id_valid && !stall && !freeze && !flush;
   assign cond_pass = issue && cond_true;
   assign cond_fail = issue && !cond_true;

   assign inc = cond_pass && id_s;
   assign dec = ex_flags_valid && !pend_zero;

   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = '0;
      end else if (inc && !dec) begin
         pending_d = pending_q + CNT_ONE;
      end else if (dec && !inc) begin
         pending_d = pending_q - CNT_ONE;
      end
   end

   // The EX writer is older than any branch, so SR updates even on flush.
   assign sr_nzcv_d = ex_flags_valid ? ex_nzcv : sr_nzcv_q;
   assign err_d     = err_q || (ex_flags_valid && pend_zero);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall)  state_d = HOLD;
         HOLD:    if (!stall) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Debug stall counter: down-counter from all-ones, saturating at zero.
   always_comb begin
      stall_left_d = stall_left_q;
      if ((state_q == HOLD) && (stall_left_q != '0)) begin
         stall_left_d = stall_left_q - DBG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         sr_nzcv_q    <= '0;
         pending_q    <= '0;
         err_q        <= 1'b0;
         stall_left_q <= '1;
      end else begin
         state_q      <= state_d;
         sr_nzcv_q    <= sr_nzcv_d;
         pending_q    <= pending_d;
         err_q        <= err_d;
         stall_left_q <= stall_left_d;
      end
   end

   assign sr_nzcv = sr_nzcv_q;
   assign pending = pending_q;
   assign err     = err_q;

endmodule

// File: tb/tb_cond_flag_ctrl.sv
module tb_cond_flag_ctrl;

   localparam int CNT_W = 2;
   localparam int MAXP  = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             id_valid = 1'b0;
   logic [3:0]       id_cond = 4'd0;
   logic             id_s = 1'b0;
   logic             freeze = 1'b0;
   logic             flush = 1'b0;
   logic             ex_flags_valid = 1'b0;
   logic [3:0]       ex_nzcv = 4'd0;
   logic             stall, cond_pass, cond_fail, err;
   logic [3:0]       sr_nzcv;
   logic [CNT_W-1:0] pending;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [3:0] m_sr;
   int         m_pend;
   bit         m_err;

   cond_flag_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_cond(id_cond),
      .id_s(id_s), .freeze(freeze), .flush(flush),
      .ex_flags_valid(ex_flags_valid), .ex_nzcv(ex_nzcv), .stall(stall),
      .cond_pass(cond_pass), .cond_fail(cond_fail), .sr_nzcv(sr_nzcv),
      .pending(pending), .err(err)
   );

   always #5 clk = ~clk;

   // Conditions come in complementary pairs: odd codes negate the even one.
   function automatic bit ref_dec(input int c, input logic [3:0] f);
      bit n, z, cc, vv, base;
      n = f[3]; z = f[2]; cc = f[1]; vv = f[0];
      case (c / 2)
         0: base = z;
         1: base = cc;
         2: base = n;
         3: base = vv;
         4: base = cc && !z;
         5: base = (n == vv);
         6: base = !z && (n == vv);
         default: base = 1'b1;
      endcase
      return (c % 2 == 1) ? !base : base;
   endfunction

   task automatic model_reset();
      m_sr = 4'd0; m_pend = 0; m_err = 1'b0;
   endtask

   task automatic model_eval(output bit e_stall, output bit e_pass, output bit e_fail);
      bit resolved, iss, t;
      logic [3:0] f;
      resolved = (m_pend == 0) || (m_pend == 1 && ex_flags_valid);
      f = (m_pend == 0) ? m_sr : ex_nzcv;
      e_stall = id_valid && !flush &&
                ((int'(id_cond) < 14 && !resolved) ||
                 (id_s && m_pend == MAXP && !ex_flags_valid));
      iss = id_valid && !e_stall && !freeze && !flush;
      t = ref_dec(int'(id_cond), f);
      e_pass = iss && t;
      e_fail = iss && !t;
   endtask

   task automatic model_tick();
      bit s, p, fl;
      @(posedge clk);
      model_eval(s, p, fl);
      if (ex_flags_valid) begin
         if (m_pend == 0) m_err = 1'b1;
         m_sr = ex_nzcv;
      end
      if (flush) m_pend = 0;
      else m_pend = m_pend + int'(p && id_s) - int'(ex_flags_valid && m_pend > 0);
   endtask

   task automatic drive(input bit v, input int c, input bit s, input bit frz,
                        input bit fl, input bit exv, input logic [3:0] exn);
      @(negedge clk);
      id_valid = v; id_cond = 4'(c); id_s = s; freeze = frz; flush = fl;
      ex_flags_valid = exv; ex_nzcv = exn;
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_reset();
      id_valid = 1'b1; id_cond = 4'd0; id_s = 1'b0;
      #12;
      checks++; if (sr_nzcv !== 4'h0) begin errors++; $display("FAIL rst_sr got %0h exp 0", sr_nzcv); end
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", pending); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
      @(negedge clk); rst_n = 1'b1; #2;
      checks++; if (cond_fail !== 1'b1) begin errors++; $display("FAIL rst_eq_fail got %0b exp 1", cond_fail); end
      checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL rst_eq_pass got %0b exp 0", cond_pass); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
      model_tick();
   endtask

   task automatic test_bypass();
      drive(1, 14, 1, 0, 0, 0, 4'h0);
      checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL byp_al_pass got %0b exp 1", cond_pass); end
      model_tick();
      drive(1, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL byp_stall got %0b exp 1", stall); end
      checks++; if (pending !== 2'd1) begin errors++; $display("FAIL byp_pend1 got %0d exp 1", pending); end
      checks++; if (cond_pass !== 1'b0 || cond_fail !== 1'b0) begin errors++; $display("FAIL byp_noissue got %0b%0b exp 00", cond_pass, cond_fail); end
      model_tick();
      drive(1, 0, 0, 0, 0, 1, 4'b0100);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL byp_unstall got %0b exp 0", stall); end
      checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL byp_pass got %0b exp 1", cond_pass); end
      model_tick();
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL byp_pend0 got %0d exp 0", pending); end
      checks++; if (sr_nzcv !== 4'b0100) begin errors++; $display("FAIL byp_sr got %0h exp 4", sr_nzcv); end
      model_tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         drive(1, 14, 1, 0, 0, 0, 4'h0);
         checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL sat_issue%0d got %0b exp 1", i, cond_pass); end
         model_tick();
      end
      drive(1, 14, 1, 0, 0, 0, 4'h0);
      checks++; if (pending !== 2'd3) begin errors++; $display("FAIL sat_pend got %0d exp 3", pending); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0b exp 1", stall); end
      model_tick();
      drive(1, 14, 1, 0, 0, 1, 4'($urandom_range(15)));
      checks++; if (stall !== 1'b0 || cond_pass !== 1'b1) begin errors++; $display("FAIL sat_release got stall=%0b pass=%0b exp 0/1", stall, cond_pass); end
      model_tick();
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (pending !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", pending); end
      for (int i = 0; i < 3; i++) begin
         model_tick();
         drive(0, 0, 0, 0, 0, 1, 4'($urandom_range(15)));
      end
      model_tick();
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL sat_drain got %0d exp 0", pending); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL sat_err got %0b exp 0", err); end
      model_tick();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 2; i++) begin
         drive(1, 14, 1, 0, 0, 0, 4'h0);
         model_tick();
      end
      drive(1, 0, 0, 0, 1, 1, 4'b1001);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0b exp 0", stall); end
      checks++; if (cond_pass !== 1'b0 || cond_fail !== 1'b0) begin errors++; $display("FAIL fl_issue got %0b%0b exp 00", cond_pass, cond_fail); end
      model_tick();
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL fl_pend got %0d exp 0", pending); end
      checks++; if (sr_nzcv !== 4'b1001) begin errors++; $display("FAIL fl_sr got %0h exp 9", sr_nzcv); end
      model_tick();
   endtask

   task automatic test_decode_sweep();
      bit exp_t;
      for (int val = 0; val < 16; val++) begin
         drive(1, 14, 1, 0, 0, 0, 4'h0);
         model_tick();
         drive(0, 0, 0, 0, 0, 1, 4'(val));
         model_tick();
         for (int c = 0; c < 16; c++) begin
            drive(1, c, 0, 0, 0, 0, 4'h0);
            exp_t = ref_dec(c, 4'(val));
            checks++;
            if (cond_pass !== exp_t || cond_fail !== !exp_t || stall !== 1'b0) begin
               errors++;
               $display("FAIL dec cond=%0d sr=%0h got pass=%0b fail=%0b stall=%0b exp pass=%0b", c, val, cond_pass, cond_fail, stall, exp_t);
            end
            model_tick();
         end
      end
   endtask

   task automatic test_err();
      drive(0, 0, 0, 0, 0, 1, 4'b0011);
      model_tick();
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (err !== 1'b1 || sr_nzcv !== 4'b0011 || pending !== 2'd0) begin errors++; $display("FAIL err_set got err=%0b sr=%0h pend=%0d exp 1/3/0", err, sr_nzcv, pending); end
      model_tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 14, 1, 0, 0, 0, 4'h0);
         model_tick();
         drive(0, 0, 0, 0, 0, 1, 4'h0);
         model_tick();
      end
      drive(0, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", err); end
      model_tick();
   endtask

   task automatic test_async_reset();
      drive(1, 14, 1, 0, 0, 0, 4'h0);
      model_tick();
      drive(1, 0, 0, 0, 0, 0, 4'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall got %0b exp 1", stall); end
      #1 rst_n = 1'b0; model_reset();
      #1;
      checks++; if (stall !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL ar_stall_pend got %0b/%0d exp 0/0", stall, pending); end
      checks++; if (sr_nzcv !== 4'h0 || err !== 1'b0) begin errors++; $display("FAIL ar_sr_err got %0h/%0b exp 0/0", sr_nzcv, err); end
      id_valid = 1'b0; #1;
      checks++; if (cond_pass !== 1'b0 || cond_fail !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ar_outs got %0b%0b%0b exp 000", cond_pass, cond_fail, stall); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit e_stall, e_pass, e_fail;
      bit exv;
      for (int i = 0; i < 3000; i++) begin
         exv = (m_pend > 0) ? ($urandom_range(1) == 1) : ($urandom_range(31) == 0);
         drive($urandom_range(3) != 0, $urandom_range(15), $urandom_range(1) == 1,
               $urandom_range(7) == 0, $urandom_range(15) == 0, exv, 4'($urandom_range(15)));
         model_eval(e_stall, e_pass, e_fail);
         checks++;
         if (stall !== e_stall || cond_pass !== e_pass || cond_fail !== e_fail) begin
            errors++;
            $display("FAIL rnd_ctl cyc=%0d got s/p/f=%0b%0b%0b exp %0b%0b%0b", i, stall, cond_pass, cond_fail, e_stall, e_pass, e_fail);
         end
         checks++;
         if (sr_nzcv !== m_sr || int'(pending) != m_pend || err !== m_err) begin
            errors++;
            $display("FAIL rnd_state cyc=%0d got sr=%0h pend=%0d err=%0b exp sr=%0h pend=%0d err=%0b", i, sr_nzcv, pending, err, m_sr, m_pend, m_err);
         end
         model_tick();
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_saturation();
      test_flush();
      test_decode_sweep();
      test_err();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
